// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Result is written DATA+2 cycles after start; busy covers the CALC and FIX states.
module mult_div_unit #(
  parameter int DATA = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [DATA-1:0] src_a,
  input  logic [DATA-1:0] src_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [DATA-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic [DATA-1:0] hi,
  output logic [DATA-1:0] lo
);

  localparam int CW = $clog2(DATA) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            is_div, neg_q, neg_r, div0;
  logic [DATA-1:0] a_raw, b_mag;
  logic [DATA-1:0] acc_hi, acc_lo;

  logic            signed_op, a_neg, b_neg;
  logic [DATA-1:0] a_mag, b_abs;
  logic [DATA:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [DATA-1:0] div_rem;
  logic [2*DATA-1:0] prod, prod_fix;
  logic [DATA-1:0] quo_fix, rem_fix;

  assign busy = (state != S_IDLE);

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & src_a[DATA-1];
    b_neg     = signed_op & src_b[DATA-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_abs     = b_neg ? -src_b : src_b;
  end

  // Multiply shifts the accumulator right; acc_lo holds the multiplier bits
  // still to be consumed. Divide shifts left; acc_lo collects quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc_hi, acc_lo[DATA-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_rem   = div_ge ? DATA'(div_shift - {1'b0, b_mag}) : div_shift[DATA-1:0];
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = div0 ? {DATA{1'b1}} : (neg_q ? -acc_lo : acc_lo);
    rem_fix  = div0 ? a_raw : (neg_r ? -acc_hi : acc_hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
      b_mag  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            state  <= S_CALC;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= op[1] & (src_b == '0);
            a_raw  <= src_a;
            b_mag  <= b_abs;
            acc_hi <= '0;
            acc_lo <= a_mag;
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc_hi <= div_rem;
            acc_lo <= {acc_lo[DATA-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[DATA:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DATA - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
